vc_wrr_pop_arbiter: RTL
=======================

Name: vc_wrr_pop_arbiter

Overview:
Weighted round-robin arbiter that drains the two virtual-channel FIFOs (VC0, VC1) onto a single shared path feeding the destination demux (D0/D1 FIFOs). It sits downstream of the VC FIFOs and upstream of the destination demux. It generates combinational pop strobes into the VC FIFOs. It registers the popped word and a valid flag toward the demux. A VC is served only when the destination FIFO its head word targets has room.

Parameters:
DATA_WIDTH, 6, word width of VC FIFO outputs and arbiter output
DEST_BIT, 4, bit index of the head word that selects destination (0 -> D0, 1 -> D1)
WEIGHT_VC0, 4, max consecutive grants to VC0 before yielding (1..15)
WEIGHT_VC1, 1, max consecutive grants to VC1 before yielding (1..15)
CNT_WIDTH, 4, width of the burst counter; must hold max(WEIGHT_VC0, WEIGHT_VC1)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
VC0_empty  input  1  VC0 FIFO empty
VC0_data_out  input  DATA_WIDTH  VC0 head word, show-ahead, valid when !VC0_empty
VC1_empty  input  1  VC1 FIFO empty
VC1_data_out  input  DATA_WIDTH  VC1 head word, show-ahead
D0_almost_full  input  1  destination FIFO D0 almost full
D1_almost_full  input  1  destination FIFO D1 almost full
VC0_rd  output  1  combinational pop strobe to VC0
VC1_rd  output  1  combinational pop strobe to VC1
arb_data_out  output  DATA_WIDTH  registered popped word to demux
arb_valid_out  output  1  registered valid for arb_data_out
arb_vc_out  output  1  registered VC id of arb_data_out (0/1)
arb_idle  output  1  registered; 1 when both VCs empty and arb_valid_out=0

Behaviour:
- Reset (async, any time): cur_vc=0, burst_cnt=0, arb_data_out=0, arb_valid_out=0, arb_vc_out=0, arb_idle=1. VC0_rd=VC1_rd=0 while reset is high. An in-flight word is discarded.
- Eligibility, combinational: eligN = !VCN_empty && !(VCN_data_out[DEST_BIT] ? D1_almost_full : D0_almost_full).
- Grant, combinational: g0 = elig0 && (cur_vc==0 || !elig1); g1 = elig1 && (cur_vc==1 || !elig0). At most one grant is active. VC0_rd=g0, VC1_rd=g1.
- Work-conserving: a lone eligible VC is always granted, regardless of weight.
- State update, one register pair {cur_vc, burst_cnt}:
  - Grant to cur_vc: burst_cnt+1. If the result equals the weight of cur_vc, cur_vc flips and burst_cnt=0.
  - Grant to the other VC: cur_vc = that VC, burst_cnt=1. If that VC's weight==1, cur_vc flips back and burst_cnt=0.
  - No grant: hold both registers.
- Output latency 1 cycle. On a grant in cycle N, the following hold at N+1:
  - arb_data_out = granted head word
  - arb_valid_out = 1
  - arb_vc_out = granted VC
  With no grant in cycle N: arb_data_out=0 and arb_valid_out=0 at N+1; arb_vc_out holds.
- Never pop an empty FIFO. Almost_full is sampled in the same cycle as the pop; the slack in the almost_full threshold absorbs the 1-cycle output pipeline.
- Head-of-line: a VC whose head word targets a blocked destination is ineligible, even if later words could pass. The other VC is served in the meantime.
- Both VCs ineligible: no pops and no state change; valid drops the next cycle.
- arb_idle next = VC0_empty && VC1_empty && !(g0||g1).

Test Plan:
- Reset asserted mid-stream while arb_valid_out=1 -> outputs go to 0 and arb_idle to 1 immediately (asynchronously). After release with both VCs empty, no rd pulses.
- VC0 holds 3 words (0x01, 0x02, 0x03, dest D0), VC1 empty -> VC0_rd high for 3 consecutive cycles. arb_data_out shows 0x01/0x02/0x03 one cycle later with valid=1 and arb_vc_out=0.
- Both VCs full, destinations free, WEIGHT_VC0=4, WEIGHT_VC1=1 -> grant sequence 0,0,0,0,1,0,0,0,0,1 repeats. No cycle has both rd high.
- VC0 head=0x10 (dest D1), D1_almost_full=1, VC1 head=0x05 (dest D0) -> VC1 is popped every cycle and VC0_rd stays 0. Dropping D1_almost_full -> VC0 is granted in the same cycle.
- D0_almost_full=D1_almost_full=1 with both VCs non-empty -> no rd pulses and arb_valid_out=0 from the next cycle; cur_vc and burst_cnt remain unchanged.
- WEIGHT_VC1=1 and a VC0 burst interrupted after 2 grants (VC0_empty) -> VC1 is granted once and cur_vc flips back to 0 with burst_cnt=0. Refilling VC0 with VC1 still non-empty -> VC0 gets 4 grants.

Source files
------------

// File: rtl/vc_wrr_pop_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : vc_wrr_pop_arbiter
// Brief   : Weighted round-robin pop arbiter draining VC0/VC1 onto one path,
//           serving a VC only when its head word's destination has room.
// Revision: 1.0 - initial release
// ============================================================================
module vc_wrr_pop_arbiter #(
    parameter int DATA_WIDTH = 6,
    parameter int DEST_BIT   = 4,
    parameter int WEIGHT_VC0 = 4,
    parameter int WEIGHT_VC1 = 1,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  VC0_empty,
    input  logic [DATA_WIDTH-1:0] VC0_data_out,
    input  logic                  VC1_empty,
    input  logic [DATA_WIDTH-1:0] VC1_data_out,
    input  logic                  D0_almost_full,
    input  logic                  D1_almost_full,
    output logic                  VC0_rd,
    output logic                  VC1_rd,
    output logic [DATA_WIDTH-1:0] arb_data_out,
    output logic                  arb_valid_out,
    output logic                  arb_vc_out,
    output logic                  arb_idle
);

    localparam logic [CNT_WIDTH-1:0] c_w0  = CNT_WIDTH'(WEIGHT_VC0);
    localparam logic [CNT_WIDTH-1:0] c_w1  = CNT_WIDTH'(WEIGHT_VC1);
    localparam logic [CNT_WIDTH-1:0] c_one = CNT_WIDTH'(1);

    logic                  r_cur_vc;
    logic [CNT_WIDTH-1:0]  r_burst_cnt;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  r_vc;
    logic                  r_idle;

    logic                  w_elig0;
    logic                  w_elig1;
    logic                  w_g0;
    logic                  w_g1;
    logic                  w_gnt;
    logic                  w_gnt_vc;
    logic [DATA_WIDTH-1:0] w_gnt_data;
    logic [CNT_WIDTH-1:0]  w_gnt_weight;
    logic [CNT_WIDTH-1:0]  w_cnt_inc;
    logic                  w_cur_vc_nxt;
    logic [CNT_WIDTH-1:0]  w_burst_cnt_nxt;

    assign w_elig0 = !VC0_empty &&
                     !(VC0_data_out[DEST_BIT] ? D1_almost_full : D0_almost_full);
    assign w_elig1 = !VC1_empty &&
                     !(VC1_data_out[DEST_BIT] ? D1_almost_full : D0_almost_full);

    // Current VC wins ties; a lone eligible VC always wins (work-conserving).
    assign w_g0 = w_elig0 && (!r_cur_vc || !w_elig1);
    assign w_g1 = w_elig1 && ( r_cur_vc || !w_elig0);

    assign VC0_rd = w_g0 && !reset;
    assign VC1_rd = w_g1 && !reset;

    always_comb begin
        w_gnt           = w_g0 || w_g1;
        w_gnt_vc        = w_g1;
        w_gnt_data      = w_g1 ? VC1_data_out : VC0_data_out;
        w_gnt_weight    = w_g1 ? c_w1 : c_w0;
        // A grant to the other VC starts a fresh burst of length one.
        w_cnt_inc       = ((w_gnt_vc == r_cur_vc) ? r_burst_cnt : '0) + c_one;
        w_cur_vc_nxt    = r_cur_vc;
        w_burst_cnt_nxt = r_burst_cnt;
        if (w_gnt) begin
            if (w_cnt_inc == w_gnt_weight) begin
                w_cur_vc_nxt    = !w_gnt_vc;
                w_burst_cnt_nxt = '0;
            end else begin
                w_cur_vc_nxt    = w_gnt_vc;
                w_burst_cnt_nxt = w_cnt_inc;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cur_vc    <= 1'b0;
            r_burst_cnt <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_vc        <= 1'b0;
            r_idle      <= 1'b1;
        end else begin
            r_cur_vc    <= w_cur_vc_nxt;
            r_burst_cnt <= w_burst_cnt_nxt;
            r_data      <= w_gnt ? w_gnt_data : '0;
            r_valid     <= w_gnt;
            if (w_gnt) begin
                r_vc <= w_gnt_vc;
            end
            r_idle      <= VC0_empty && VC1_empty && !w_gnt;
        end
    end

    assign arb_data_out  = r_data;
    assign arb_valid_out = r_valid;
    assign arb_vc_out    = r_vc;
    assign arb_idle      = r_idle;

endmodule
`default_nettype wire
